instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 167 ++++++++++++++++
 tb/tb_instr_encoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
// Encodes R-type / load / store / branch-equal requests into 32-bit MIPS-style
// instruction words and buffers them in a small FIFO. Each word is presented
// with the byte address it should be written to in instruction memory.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   in_valid / in_ready         request handshake (in_ready = FIFO not full)
//   in_kind                     0=R, 1=load, 2=store, 3=beq, 4..7 illegal
//   in_rs/rt/rd/shamt/funct/imm instruction fields
//   out_valid / out_ready       head-word handshake (out_valid = FIFO not empty)
//   out_word, out_addr          head word and its byte address
//   addr_load, start_addr       reload the address counter
//   words_sent                  words popped since reset (wraps)
//   err, err_clr                sticky illegal-kind flag and its clear
//
// Build option: define ENC_CHECK_EN to drop illegal kinds (4..7) and raise err.
// Without it, in_kind[2] is ignored and err is constant 0.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [5:0]  in_funct,
    input  logic [15:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    input  logic        addr_load,
    input  logic [31:0] start_addr,
    output logic [15:0] words_sent,
    output logic        err,
    input  logic        err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] C_ZERO  = '0;
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);

    logic [31:0]   r_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_head;
    logic [31:0]   r_addr;
    logic [15:0]   r_sent;

    logic          w_full;
    logic          w_accept;
    logic          w_pop;
    logic          w_illegal;
    logic          w_push;
    logic [31:0]   w_word;
    logic [31:0]   w_head_next;
    logic [AW:0]   w_count_next;
    logic [AW-1:0] w_rptr_inc;

    assign w_full     = (r_count == C_DEPTH);
    assign in_ready   = ~w_full;
    assign out_valid  = (r_count != C_ZERO);
    assign w_accept   = in_valid & in_ready;
    assign w_pop      = out_valid & out_ready;
    assign w_push     = w_accept & ~w_illegal;
    assign w_rptr_inc = r_rptr + 1'b1;

    assign out_word   = r_head;
    assign out_addr   = r_addr;
    assign words_sent = r_sent;

    // Only the low two kind bits select the format; illegal kinds are either
    // filtered (checked build) or aliased onto 0..3.
    always_comb begin
        w_word = '0;
        case (in_kind[1:0])
            2'd0: w_word = {6'd0,  in_rs, in_rt, in_rd, in_shamt, in_funct};
            2'd1: w_word = {6'd35, in_rs, in_rt, in_imm};
            2'd2: w_word = {6'd43, in_rs, in_rt, in_imm};
            2'd3: w_word = {6'd4,  in_rs, in_rt, in_imm};
            default: w_word = '0;
        endcase
    end

    // out_word is a dedicated register holding the FIFO head so that it can
    // keep its last value when the FIFO drains and has no path from inputs.
    always_comb begin
        w_head_next = r_head;
        if (w_pop) begin
            if (r_count > C_ONE)
                w_head_next = r_mem[w_rptr_inc];
            else if (w_push)
                w_head_next = w_word;
        end else if ((r_count == C_ZERO) && w_push) begin
            w_head_next = w_word;
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + C_ONE;
            2'b01:   w_count_next = r_count - C_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push)
            r_mem[r_wptr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_addr  <= '0;
            r_sent  <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= w_rptr_inc;
            r_count <= w_count_next;
            r_head  <= w_head_next;
            // A reload wins over the increment of a simultaneous pop.
            if (addr_load)
                r_addr <= start_addr;
            else if (w_pop)
                r_addr <= r_addr + 32'd4;
            if (w_pop)
                r_sent <= r_sent + 16'd1;
        end
    end

`ifdef ENC_CHECK_EN
    logic r_err;

    assign w_illegal = in_kind[2];
    assign err       = r_err;

    // Setting by a new illegal request wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset)
            r_err <= 1'b0;
        else if (w_accept && w_illegal)
            r_err <= 1'b1;
        else if (err_clr)
            r_err <= 1'b0;
    end
`else
    logic w_unused;

    assign w_illegal = 1'b0;
    assign err       = 1'b0;
    assign w_unused  = &{1'b0, err_clr, in_kind[2]};
`endif

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        addr_load;
    logic [31:0] start_addr;
    logic [15:0] words_sent;
    logic        err;
    logic        err_clr;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_addr;
    logic [15:0] m_sent;
    logic        m_err;
    logic [31:0] m_last;

    always #5 clk = ~clk;

    instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr),
        .addr_load(addr_load), .start_addr(start_addr),
        .words_sent(words_sent), .err(err), .err_clr(err_clr)
    );

    function automatic bit ref_illegal(input logic [2:0] k);
`ifdef ENC_CHECK_EN
        return k >= 3'd4;
`else
        return 1'b0;
`endif
    endfunction

    // Instruction formats straight from the opcode table.
    function automatic logic [31:0] ref_encode(input int kind, input int rs, input int rt,
                                               input int rd, input int sh, input int fn,
                                               input int imm);
        int op;
        kind = kind % 4;
        if (kind == 0)
            return (rs << 21) + (rt << 16) + (rd << 11) + (sh << 6) + fn;
        op = (kind == 1) ? 35 : (kind == 2) ? 43 : 4;
        return (op << 26) + (rs << 21) + (rt << 16) + imm;
    endfunction

    // Advance one clock and update the model with what the edge did.
    task automatic tick();
        bit acc, pop;
        acc = in_valid && (mq.size() < DEPTH);
        pop = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_addr = 0; m_sent = 0; m_err = 0; m_last = 0;
        end else begin
            if (pop) begin
                m_last = mq.pop_front();
                m_addr = m_addr + 32'd4;
                m_sent = m_sent + 16'd1;
            end
            if (addr_load) m_addr = start_addr;
            if (acc && ref_illegal(in_kind)) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (acc && !ref_illegal(in_kind))
                mq.push_back(ref_encode(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd),
                                        int'(in_shamt), int'(in_funct), int'(in_imm)));
        end
        #1;
    endtask

    task automatic rand_fields(input bit legal_only);
        in_kind  = legal_only ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        in_rs    = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
        in_shamt = 5'($urandom); in_funct = 6'($urandom); in_imm = 16'($urandom);
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; out_ready = 0; addr_load = 0; err_clr = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (out_addr !== 32'd0) $display("FAIL reset_out_addr: got %h expected 0", out_addr); else n_pass++;
        n_total++; if (words_sent !== 16'd0) $display("FAIL reset_words_sent: got %h expected 0", words_sent); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        n_total++; if (out_word !== 32'd0) $display("FAIL reset_out_word: got %h expected 0", out_word); else n_pass++;
    endtask

    task automatic test_encoding();
        logic [31:0] exp_w [4];
        logic [2:0]  kinds [4];
        logic [4:0]  rss [4], rts [4];
        logic [15:0] imms [4];
        exp_w[0] = 32'h00221820; exp_w[1] = 32'h8FA80004; exp_w[2] = 32'hAFA80008; exp_w[3] = 32'h1022FFFF;
        kinds[0] = 3'd0; kinds[1] = 3'd1; kinds[2] = 3'd2; kinds[3] = 3'd3;
        rss[0] = 5'd1; rss[1] = 5'd29; rss[2] = 5'd29; rss[3] = 5'd1;
        rts[0] = 5'd2; rts[1] = 5'd8;  rts[2] = 5'd8;  rts[3] = 5'd2;
        imms[0] = 16'h1234; imms[1] = 16'd4; imms[2] = 16'd8; imms[3] = 16'hFFFF;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_kind = kinds[i]; in_rs = rss[i]; in_rt = rts[i];
            in_rd = (i == 0) ? 5'd3 : 5'd31; in_shamt = (i == 0) ? 5'd0 : 5'd17;
            in_funct = (i == 0) ? 6'h20 : 6'h3F; in_imm = imms[i];
            tick();
            in_valid = 0;
            n_total++; if (out_valid !== 1'b1 || out_word !== exp_w[i])
                $display("FAIL enc_word%0d: got valid=%b word=%h expected valid=1 word=%h", i, out_valid, out_word, exp_w[i]);
            else n_pass++;
            out_ready = 1; tick(); out_ready = 0;
        end
        n_total++; if (out_valid !== 1'b0 || out_word !== exp_w[3])
            $display("FAIL enc_empty_hold: got valid=%b word=%h expected valid=0 word=%h", out_valid, out_word, exp_w[3]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; rand_fields(1);
            if (i == 4) begin
                n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", in_ready); else n_pass++;
            end
            tick();
        end
        in_valid = 0;
        n_total++; if (mq.size() != 4 || in_ready !== 1'b0)
            $display("FAIL bp_accepted: got in_ready=%b model_count=%0d expected in_ready=0 count=4", in_ready, mq.size());
        else n_pass++;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (out_addr !== 32'(i * 4) || out_word !== mq[0])
                $display("FAIL bp_pop%0d: got addr=%h word=%h expected addr=%h word=%h", i, out_addr, out_word, 32'(i * 4), mq[0]);
            else n_pass++;
            tick();
            if (i == 0) begin
                n_total++; if (in_ready !== 1'b1) $display("FAIL bp_slot_freed: got %b expected 1", in_ready); else n_pass++;
            end
        end
        out_ready = 0;
        n_total++; if (words_sent !== 16'd4 || out_valid !== 1'b0)
            $display("FAIL bp_done: got sent=%0d valid=%b expected sent=4 valid=0", words_sent, out_valid);
        else n_pass++;
    endtask

    task automatic test_addr_control();
        logic [31:0] exp_a [3];
        exp_a[0] = 32'hFFFFFFF8; exp_a[1] = 32'hFFFFFFFC; exp_a[2] = 32'h00000000;
        do_reset();
        addr_load = 1; start_addr = 32'hFFFFFFF8; tick(); addr_load = 0;
        for (int i = 0; i < 3; i++) begin in_valid = 1; rand_fields(1); tick(); end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (out_addr !== exp_a[i]) $display("FAIL addr_wrap%0d: got %h expected %h", i, out_addr, exp_a[i]); else n_pass++;
            tick();
        end
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin in_valid = 1; rand_fields(1); tick(); end
        in_valid = 0; out_ready = 1; addr_load = 1; start_addr = 32'h00001000;
        tick();
        out_ready = 0; addr_load = 0;
        n_total++; if (out_addr !== 32'h00001000 || out_valid !== 1'b1 || out_word !== mq[0] || mq.size() != 1)
            $display("FAIL addr_load_pop: got addr=%h valid=%b word=%h expected addr=00001000 valid=1 word=%h",
                     out_addr, out_valid, out_word, mq[0]);
        else n_pass++;
    endtask

    task automatic test_streaming();
        do_reset();
        in_valid = 1; rand_fields(1); tick();
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            rand_fields(1);
            n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_word !== mq[0])
                $display("FAIL stream%0d: got ready=%b valid=%b word=%h expected 1 1 %h", i, in_ready, out_valid, out_word, mq[0]);
            else n_pass++;
            tick();
        end
        in_valid = 0; out_ready = 0;
        n_total++; if (words_sent !== 16'd8 || mq.size() != 1)
            $display("FAIL stream_count: got sent=%0d model_count=%0d expected 8 1", words_sent, mq.size());
        else n_pass++;
    endtask

    task automatic test_illegal();
        do_reset();
        in_valid = 1; rand_fields(1); in_kind = 3'd5; in_rs = 5'd29; in_rt = 5'd8; in_imm = 16'd4;
        tick();
        in_valid = 0;
`ifdef ENC_CHECK_EN
        n_total++; if (out_valid !== 1'b0 || err !== 1'b1)
            $display("FAIL ill_drop: got valid=%b err=%b expected valid=0 err=1", out_valid, err);
        else n_pass++;
        err_clr = 1; tick(); err_clr = 0;
        n_total++; if (err !== 1'b0) $display("FAIL ill_clear: got %b expected 0", err); else n_pass++;
        in_valid = 1; in_kind = 3'd7; err_clr = 1; tick(); in_valid = 0; err_clr = 0;
        n_total++; if (err !== 1'b1) $display("FAIL ill_set_wins: got %b expected 1", err); else n_pass++;
`else
        n_total++; if (out_valid !== 1'b1 || out_word !== 32'h8FA80004 || err !== 1'b0)
            $display("FAIL ill_alias: got valid=%b word=%h err=%b expected 1 8fa80004 0", out_valid, out_word, err);
        else n_pass++;
        err_clr = 1; tick(); err_clr = 0;
        n_total++; if (err !== 1'b0) $display("FAIL ill_err_tied: got %b expected 0", err); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin in_valid = 1; rand_fields(1); tick(); end
        in_valid = 0; out_ready = 1; tick(); out_ready = 0;
        in_valid = 1; rand_fields(1); out_ready = 1; addr_load = 1; start_addr = 32'h40; reset = 1;
        tick();
        reset = 0; in_valid = 0; out_ready = 0; addr_load = 0;
        n_total++; if (out_valid !== 1'b0 || out_addr !== 32'd0 || words_sent !== 16'd0 || in_ready !== 1'b1)
            $display("FAIL reset_mid: got valid=%b addr=%h sent=%0d ready=%b expected 0 0 0 1", out_valid, out_addr, words_sent, in_ready);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            addr_load  = ($urandom_range(0, 19) == 0);
            start_addr = {$urandom_range(0, 1) == 1 ? 28'hFFFFFFF : 28'($urandom), 4'($urandom_range(0, 3) * 4)};
            err_clr    = ($urandom_range(0, 9) == 0);
            reset      = ($urandom_range(0, 99) == 0);
            rand_fields(0);
            n_total++; if (in_ready !== (mq.size() < DEPTH) || out_valid !== (mq.size() > 0))
                $display("FAIL rnd_flags%0d: got ready=%b valid=%b expected ready=%b valid=%b",
                         i, in_ready, out_valid, mq.size() < DEPTH, mq.size() > 0);
            else n_pass++;
            n_total++; if (out_word !== ((mq.size() > 0) ? mq[0] : m_last) || out_addr !== m_addr)
                $display("FAIL rnd_data%0d: got word=%h addr=%h expected word=%h addr=%h",
                         i, out_word, out_addr, (mq.size() > 0) ? mq[0] : m_last, m_addr);
            else n_pass++;
            n_total++; if (words_sent !== m_sent || err !== m_err)
                $display("FAIL rnd_stat%0d: got sent=%0d err=%b expected sent=%0d err=%b", i, words_sent, err, m_sent, m_err);
            else n_pass++;
            tick();
        end
        reset = 0; in_valid = 0; out_ready = 0; addr_load = 0; err_clr = 0;
    endtask

    initial begin
        reset = 1; in_valid = 0; out_ready = 0; addr_load = 0; err_clr = 0;
        start_addr = 0; in_kind = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_shamt = 0; in_funct = 0; in_imm = 0;
        m_addr = 0; m_sent = 0; m_err = 0; m_last = 0;
        #1;
        test_reset();
        test_encoding();
        test_backpressure();
        test_addr_control();
        test_streaming();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
